// File: rtl/onewire_slave.sv
// One-wire link responder: decodes 56-bit command frames on bus1, executes them against a
// 4 x 32-bit register file and answers with a 56-bit response frame on open-drain bus2.
module onewire_slave #(
  parameter int unsigned BIT_PERIOD = 64
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         bus1,
  inout  wire         bus2,
  output logic [55:0] o_command,
  output logic        o_cmd_valid,
  output logic        o_error,
  output logic        o_busy
);

  localparam int unsigned CntW = $clog2(9 * BIT_PERIOD) + 1;

  localparam logic [CntW-1:0] StartLen = CntW'(4 * BIT_PERIOD);
  localparam logic [CntW-1:0] OneMax   = CntW'(BIT_PERIOD / 2);
  localparam logic [CntW-1:0] ZeroMax  = CntW'(BIT_PERIOD);
  localparam logic [CntW-1:0] HighMax  = CntW'(2 * BIT_PERIOD + 1);
  localparam logic [CntW-1:0] WaitLast = CntW'(BIT_PERIOD - 1);
  localparam logic [CntW-1:0] RstLow   = CntW'(8 * BIT_PERIOD);
  localparam logic [CntW-1:0] RstLast  = CntW'(9 * BIT_PERIOD - 1);
  localparam logic [CntW-1:0] SlotLast = CntW'(BIT_PERIOD - 1);
  localparam logic [CntW-1:0] LowOne   = CntW'(BIT_PERIOD / 4);
  localparam logic [CntW-1:0] LowZero  = CntW'(3 * BIT_PERIOD / 4);

  localparam logic [7:0] OpWrite   = 8'h01;
  localparam logic [7:0] OpRead    = 8'h02;
  localparam logic [7:0] OpWrAck   = 8'h81;
  localparam logic [7:0] OpRdAck   = 8'h82;
  localparam logic [7:0] OpInvalid = 8'hFF;

  typedef enum logic [2:0] {
    StRxIdle,
    StRxBits,
    StExec,
    StTxWait,
    StTxRst,
    StTxBits
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync_q;
  logic              prev_q;
  logic              rise_q;
  logic [CntW-1:0]   low_cnt_q;
  logic [CntW-1:0]   len_q;
  logic [CntW-1:0]   high_cnt_q;
  logic [5:0]        rx_idx_q, rx_idx_d;
  logic [55:0]       frame_q, frame_d;
  logic              line_err_q, line_err_d;
  logic [CntW-1:0]   tx_cnt_q, tx_cnt_d;
  logic [5:0]        tx_idx_q, tx_idx_d;
  logic [55:0]       resp_q;
  logic [31:0]       regs_q [4];

  // ---------------------------------------------------------------------------
  // Receive front end: synchroniser, low/high pulse timers, rising-edge register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      rise_q     <= 1'b0;
      low_cnt_q  <= '0;
      len_q      <= '0;
      high_cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], bus1};
      prev_q <= sync_q[1];
      rise_q <= sync_q[1] & ~prev_q;
      if (sync_q[1] && !prev_q) begin
        len_q <= low_cnt_q;
      end
      // Both timers saturate just past the longest length they need to tell apart.
      if (!sync_q[1]) begin
        high_cnt_q <= '0;
        if (low_cnt_q != StartLen) begin
          low_cnt_q <= low_cnt_q + 1'b1;
        end
      end else begin
        low_cnt_q <= '0;
        if (high_cnt_q != HighMax) begin
          high_cnt_q <= high_cnt_q + 1'b1;
        end
      end
    end
  end

  logic is_start;
  assign is_start = rise_q && (len_q >= StartLen);

  // ---------------------------------------------------------------------------
  // Frame decode and response construction.
  // ---------------------------------------------------------------------------
  logic [7:0]  cmd_op, cmd_addr, cmd_cks, cmd_xor;
  logic [31:0] cmd_data;
  logic [1:0]  reg_idx;
  logic        frame_valid;

  assign cmd_op   = frame_q[7:0];
  assign cmd_addr = frame_q[15:8];
  assign cmd_data = frame_q[47:16];
  assign cmd_cks  = frame_q[55:48];
  assign cmd_xor  = cmd_op ^ cmd_addr ^ cmd_data[7:0] ^ cmd_data[15:8] ^ cmd_data[23:16] ^
                    cmd_data[31:24];
  assign reg_idx  = cmd_addr[1:0];
  assign frame_valid = (cmd_cks == cmd_xor) && ((cmd_op == OpWrite) || (cmd_op == OpRead)) &&
                       (cmd_addr <= 8'd3);

  logic [7:0]  resp_op;
  logic [31:0] resp_data;
  logic [7:0]  resp_cks;

  always_comb begin
    resp_op   = OpInvalid;
    resp_data = '0;
    if (frame_valid) begin
      if (cmd_op == OpWrite) begin
        resp_op   = OpWrAck;
        resp_data = cmd_data;
      end else begin
        resp_op   = OpRdAck;
        resp_data = regs_q[reg_idx];
      end
    end
  end

  assign resp_cks = resp_op ^ cmd_addr ^ resp_data[7:0] ^ resp_data[15:8] ^ resp_data[23:16] ^
                    resp_data[31:24];

  // ---------------------------------------------------------------------------
  // Main FSM.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rx_idx_d   = rx_idx_q;
    frame_d    = frame_q;
    line_err_d = 1'b0;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    unique case (state_q)
      StRxIdle: begin
        if (is_start) begin
          state_d  = StRxBits;
          rx_idx_d = '0;
        end
      end
      StRxBits: begin
        if (is_start) begin
          rx_idx_d = '0;
        end else if (rise_q) begin
          if (len_q < ZeroMax) begin
            frame_d[rx_idx_q] = (len_q < OneMax);
            rx_idx_d          = rx_idx_q + 6'd1;
            if (rx_idx_q == 6'd55) begin
              state_d = StExec;
            end
          end else begin
            line_err_d = 1'b1;
            state_d    = StRxIdle;
          end
        end else if (high_cnt_q == HighMax) begin
          line_err_d = 1'b1;
          state_d    = StRxIdle;
        end
      end
      StExec: begin
        state_d  = StTxWait;
        tx_cnt_d = '0;
      end
      StTxWait: begin
        if (tx_cnt_q == WaitLast) begin
          state_d  = StTxRst;
          tx_cnt_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StTxRst: begin
        if (tx_cnt_q == RstLast) begin
          state_d  = StTxBits;
          tx_cnt_d = '0;
          tx_idx_d = '0;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      StTxBits: begin
        if (tx_cnt_q == SlotLast) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 6'd55) begin
            state_d = StRxIdle;
          end else begin
            tx_idx_d = tx_idx_q + 6'd1;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: state_d = StRxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StRxIdle;
      rx_idx_q   <= '0;
      frame_q    <= '0;
      line_err_q <= 1'b0;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      resp_q     <= '0;
      o_command  <= '0;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rx_idx_q   <= rx_idx_d;
      frame_q    <= frame_d;
      line_err_q <= line_err_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      if (state_q == StExec) begin
        resp_q <= {resp_cks, resp_data, cmd_addr, resp_op};
        if (frame_valid) begin
          o_command <= frame_q;
          if (cmd_op == OpWrite) begin
            regs_q[reg_idx] <= cmd_data;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. bus2 is decoded straight from state so reset releases it at once.
  // ---------------------------------------------------------------------------
  logic            tx_bit;
  logic [CntW-1:0] tx_low_len;
  logic            drive_low;

  assign tx_bit     = resp_q[tx_idx_q];
  assign tx_low_len = tx_bit ? LowOne : LowZero;
  assign drive_low  = ((state_q == StTxRst) && (tx_cnt_q < RstLow)) ||
                      ((state_q == StTxBits) && (tx_cnt_q < tx_low_len));

  assign bus2 = drive_low ? 1'b0 : 1'bz;

  assign o_cmd_valid = (state_q == StExec) && frame_valid;
  assign o_error     = line_err_q || ((state_q == StExec) && !frame_valid);
  assign o_busy      = (state_q == StExec) || (state_q == StTxWait) || (state_q == StTxRst) ||
                       (state_q == StTxBits);

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: drives command frames on bus1, decodes bus2 responses and checks
// them against a field-level model of the register file.
module tb_onewire_slave;

  localparam int unsigned BP = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        bus1_drv = 1'b1;
  wire         bus1_w;
  wire         bus2_w;
  logic [55:0] command;
  logic        cmd_valid, error, busy;

  assign bus1_w = bus1_drv;
  pullup (bus2_w);

  onewire_slave #(.BIT_PERIOD(BP)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus1       (bus1_w),
    .bus2       (bus2_w),
    .o_command  (command),
    .o_cmd_valid(cmd_valid),
    .o_error    (error),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model_regs [4];

  // ---------------------------------------------------------------------------
  // Monitors: pulse counters, busy/bus2 timestamps and a bus2 frame decoder.
  // ---------------------------------------------------------------------------
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_valid = 0, n_err = 0, n_both = 0, n_low = 0;
  int unsigned exec_cyc = 0, low_cyc = 0, err_cyc = 0;
  int          busy_run = 0, busy_len = 0, b2_len = 0, b2_idx = 0;
  logic        busy_prev = 1'b0, b2_prev_low = 1'b0, b2_active = 1'b0;
  logic [55:0] b2_buf = '0;
  logic [55:0] rx_q [$];

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) n_valid <= n_valid + 1;
    if (error === 1'b1) begin
      n_err   <= n_err + 1;
      err_cyc <= cyc;
    end
    if (cmd_valid === 1'b1 && error === 1'b1) n_both <= n_both + 1;
    if (busy === 1'b1 && !busy_prev) exec_cyc <= cyc;
    busy_prev <= (busy === 1'b1);
    if (busy === 1'b1) begin
      busy_run <= busy_run + 1;
    end else if (busy_prev) begin
      busy_len <= busy_run;
      busy_run <= 0;
    end
    b2_prev_low <= (bus2_w === 1'b0);
    if (bus2_w === 1'b0) begin
      n_low  <= n_low + 1;
      b2_len <= b2_len + 1;
      if (!b2_prev_low && !b2_active) low_cyc <= cyc;
    end else begin
      b2_len <= 0;
      if (b2_prev_low) begin
        if (b2_len >= 4 * BP) begin
          b2_active <= 1'b1;
          b2_idx    <= 0;
          b2_buf    <= '0;
        end else if (b2_active) begin
          b2_buf[b2_idx] <= (b2_len < BP / 2);
          b2_idx         <= b2_idx + 1;
          if (b2_idx == 55) begin
            rx_q.push_back({(b2_len < BP / 2) ? 1'b1 : 1'b0, b2_buf[54:0]});
            b2_active <= 1'b0;
          end
        end
      end
    end
    if (reset === 1'b0) b2_active <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Reference model: frames and responses built from the field rules.
  // ---------------------------------------------------------------------------
  function automatic logic [55:0] make_frame(input logic [7:0] op, input logic [7:0] ad,
                                             input logic [31:0] d);
    logic [7:0] c;
    c = op ^ ad ^ d[7:0] ^ d[15:8] ^ d[23:16] ^ d[31:24];
    return {c, d, ad, op};
  endfunction

  function automatic bit frame_ok(input logic [55:0] f);
    logic [7:0] c;
    c = f[7:0] ^ f[15:8] ^ f[23:16] ^ f[31:24] ^ f[39:32] ^ f[47:40];
    return (c == f[55:48]) && (f[7:0] == 8'h01 || f[7:0] == 8'h02) && (f[15:8] < 8'd4);
  endfunction

  function automatic logic [55:0] exp_resp(input logic [55:0] f);
    if (!frame_ok(f)) return make_frame(8'hFF, f[15:8], 32'h0);
    if (f[7:0] == 8'h01) return make_frame(8'h81, f[15:8], f[47:16]);
    return make_frame(8'h82, f[15:8], model_regs[f[9:8]]);
  endfunction

  task automatic model_apply(input logic [55:0] f);
    if (frame_ok(f) && f[7:0] == 8'h01) model_regs[f[9:8]] = f[47:16];
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no checking here).
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input int n);
    bus1_drv = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [55:0] f, input int nbits, input bit with_start);
    int lo;
    if (with_start) begin
      drive(1'b0, 5 * BP);
      drive(1'b1, BP);
    end
    for (int i = 0; i < nbits; i++) begin
      lo = f[i] ? BP / 4 : 3 * BP / 4;
      drive(1'b0, lo);
      drive(1'b1, BP - lo);
    end
  endtask

  task automatic wait_busy_rise(output bit to);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 16) begin
      @(posedge clk);
      #1;
      n++;
    end
    to = (busy !== 1'b1);
  endtask

  task automatic wait_done(output bit to);
    int n;
    bit t0;
    wait_busy_rise(t0);
    n = 0;
    while (busy === 1'b1 && n < 70 * BP) begin
      @(posedge clk);
      #1;
      n++;
    end
    to = t0 || (busy === 1'b1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Tests.
  // ---------------------------------------------------------------------------
  task automatic test_reset;
    n_checks++;
    if (command !== 56'h0) begin
      n_fail++; $display("FAIL reset_command: got %h expected 0", command);
    end
    n_checks++;
    if (cmd_valid !== 1'b0 || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got v=%b e=%b b=%b expected 000", cmd_valid, error, busy);
    end
    n_checks++;
    if (bus2_w !== 1'b1) begin
      n_fail++; $display("FAIL reset_bus2: got %b expected 1", bus2_w);
    end
  endtask

  task automatic test_write;
    logic [55:0] f, er, got;
    int v0, e0;
    bit to;
    f  = make_frame(8'h01, 8'h02, 32'hDEADBEEF);
    er = exp_resp(f);
    model_apply(f);
    v0 = n_valid; e0 = n_err; rx_q.delete();
    send_bits(f, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (to) begin n_fail++; $display("FAIL write_timeout: busy did not complete"); end
    n_checks++;
    if (n_valid - v0 != 1 || n_err - e0 != 0) begin
      n_fail++; $display("FAIL write_pulses: got valid=%0d err=%0d expected 1/0", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (command !== f) begin n_fail++; $display("FAIL write_command: got %h expected %h", command, f); end
    n_checks++;
    if (rx_q.size() != 1 || got !== er) begin
      n_fail++; $display("FAIL write_resp: got %h (n=%0d) expected %h", got, rx_q.size(), er);
    end
    n_checks++;
    if (low_cyc - exec_cyc != BP + 1) begin
      n_fail++; $display("FAIL resp_start: got %0d expected %0d", low_cyc - exec_cyc, BP + 1);
    end
    n_checks++;
    if (busy_len != 66 * BP + 1) begin
      n_fail++; $display("FAIL busy_len: got %0d expected %0d", busy_len, 66 * BP + 1);
    end
  endtask

  task automatic test_readback;
    logic [55:0] f, er, got;
    bit to;
    for (int k = 0; k < 2; k++) begin
      f  = make_frame(8'h02, (k == 0) ? 8'h02 : 8'h01, 32'h0);
      er = exp_resp(f);
      rx_q.delete();
      send_bits(f, 56, 1'b1);
      wait_done(to);
      got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
      n_checks++;
      if (to || rx_q.size() != 1 || got !== er) begin
        n_fail++; $display("FAIL read_%0d: got %h to=%b expected %h", k, got, to, er);
      end
    end
  endtask

  task automatic test_bad_checksum;
    logic [55:0] f, fr, er, got;
    int v0, e0;
    bit to;
    f  = make_frame(8'h01, 8'h02, 32'h12345678);
    f[48] = ~f[48];
    er = exp_resp(f);
    model_apply(f);
    v0 = n_valid; e0 = n_err; rx_q.delete();
    send_bits(f, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (to || n_valid - v0 != 0 || n_err - e0 != 1) begin
      n_fail++; $display("FAIL badcks_pulses: got valid=%0d err=%0d expected 0/1", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (got !== er) begin n_fail++; $display("FAIL badcks_resp: got %h expected %h", got, er); end
    fr = make_frame(8'h02, 8'h02, 32'h0);
    er = exp_resp(fr);
    rx_q.delete();
    send_bits(fr, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (got !== er) begin n_fail++; $display("FAIL badcks_reg: got %h expected %h", got, er); end
  endtask

  task automatic test_line_error;
    logic [55:0] f, er, got;
    int v0, e0, l0;
    bit to;
    f  = make_frame(8'h01, 8'h00, $urandom);
    v0 = n_valid; e0 = n_err; l0 = n_low;
    send_bits(f, 10, 1'b1);
    drive(1'b0, BP + 2);
    drive(1'b1, 4 * BP);
    n_checks++;
    if (n_err - e0 != 1 || n_valid - v0 != 0) begin
      n_fail++; $display("FAIL line_err: got err=%0d valid=%0d expected 1/0", n_err - e0, n_valid - v0);
    end
    n_checks++;
    if (n_low != l0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL line_err_quiet: got bus2 low cycles=%0d busy=%b expected 0/0", n_low - l0, busy);
    end
    er = exp_resp(f);
    model_apply(f);
    v0 = n_valid; rx_q.delete();
    send_bits(f, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (to || n_valid - v0 != 1 || got !== er || command !== f) begin
      n_fail++; $display("FAIL after_line_err: got %h cmd=%h expected %h cmd=%h", got, command, er, f);
    end
  endtask

  task automatic test_timeout;
    logic [55:0] f;
    int e0, l0, lo;
    int unsigned c0;
    f  = make_frame(8'h02, 8'h01, $urandom);
    e0 = n_err; l0 = n_low;
    send_bits(f, 19, 1'b1);
    lo = f[19] ? BP / 4 : 3 * BP / 4;
    drive(1'b0, lo);
    c0 = cyc;
    drive(1'b1, 4 * BP);
    n_checks++;
    if (n_err - e0 != 1) begin n_fail++; $display("FAIL timeout_err: got %0d expected 1", n_err - e0); end
    n_checks++;
    if (err_cyc - c0 != 2 * BP + 4) begin
      n_fail++; $display("FAIL timeout_time: got %0d expected %0d", err_cyc - c0, 2 * BP + 4);
    end
    n_checks++;
    if (n_low != l0) begin n_fail++; $display("FAIL timeout_quiet: got %0d low cycles expected 0", n_low - l0); end
  endtask

  task automatic test_busy_ignore;
    logic [55:0] f1, f2, er, got;
    int v0, e0;
    bit to, tr;
    f1 = make_frame(8'h01, 8'h03, $urandom);
    f2 = make_frame(8'h01, 8'h03, ~f1[47:16]);
    er = exp_resp(f1);
    model_apply(f1);
    v0 = n_valid; e0 = n_err; rx_q.delete();
    send_bits(f1, 56, 1'b1);
    wait_busy_rise(tr);
    send_bits(f2, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (tr || to || n_valid - v0 != 1 || n_err - e0 != 0) begin
      n_fail++; $display("FAIL busy_ignore_pulses: got valid=%0d err=%0d expected 1/0", n_valid - v0, n_err - e0);
    end
    n_checks++;
    if (rx_q.size() != 1 || got !== er) begin
      n_fail++; $display("FAIL busy_ignore_resp: got %h (n=%0d) expected %h", got, rx_q.size(), er);
    end
    f2 = make_frame(8'h02, 8'h03, 32'h0);
    er = exp_resp(f2);
    rx_q.delete();
    send_bits(f2, 56, 1'b1);
    wait_done(to);
    got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
    n_checks++;
    if (got !== er) begin n_fail++; $display("FAIL busy_ignore_reg: got %h expected %h", got, er); end
  endtask

  task automatic test_random;
    logic [55:0] f, er, got;
    logic [7:0]  op;
    int v0, e0;
    bit ok, to;
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h01;
        1: op = 8'h02;
        2: op = 8'h01;
        default: op = 8'($urandom);
      endcase
      f = make_frame(op, 8'($urandom_range(0, 4)), $urandom);
      if ($urandom_range(0, 3) == 0) f[55:48] = f[55:48] ^ 8'($urandom_range(1, 255));
      ok = frame_ok(f);
      er = exp_resp(f);
      model_apply(f);
      v0 = n_valid; e0 = n_err; rx_q.delete();
      send_bits(f, 56, 1'b1);
      wait_done(to);
      got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
      n_checks++;
      if (to || n_valid - v0 != int'(ok) || n_err - e0 != int'(!ok)) begin
        n_fail++; $display("FAIL rand_%0d_pulses: got valid=%0d err=%0d expected ok=%b", k, n_valid - v0, n_err - e0, ok);
      end
      n_checks++;
      if (rx_q.size() != 1 || got !== er) begin
        n_fail++; $display("FAIL rand_%0d_resp: frame %h got %h expected %h", k, f, got, er);
      end
      if (ok) begin
        n_checks++;
        if (command !== f) begin n_fail++; $display("FAIL rand_%0d_cmd: got %h expected %h", k, command, f); end
      end
    end
  endtask

  task automatic test_reset_mid_tx;
    logic [55:0] f, er, got;
    int n;
    bit to;
    f = make_frame(8'h01, 8'h01, 32'hCAFE0001);
    send_bits(f, 56, 1'b1);
    wait_busy_rise(to);
    repeat (10 * BP + 2) begin
      @(posedge clk);
      #1;
    end
    n = 0;
    while (bus2_w !== 1'b0 && n < 2 * BP) begin
      @(posedge clk);
      #1;
      n++;
    end
    n_checks++;
    if (to || busy !== 1'b1 || bus2_w !== 1'b0) begin
      n_fail++; $display("FAIL midtx_pre: got busy=%b bus2=%b expected 1/0", busy, bus2_w);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus2_w !== 1'b1 || busy !== 1'b0 || cmd_valid !== 1'b0 || error !== 1'b0 || command !== 56'h0) begin
      n_fail++; $display("FAIL midtx_reset: got bus2=%b busy=%b v=%b e=%b cmd=%h expected 1/0/0/0/0",
                         bus2_w, busy, cmd_valid, error, command);
    end
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    for (int k = 1; k < 3; k++) begin
      f  = make_frame(8'h02, 8'(k), 32'h0);
      er = exp_resp(f);
      rx_q.delete();
      send_bits(f, 56, 1'b1);
      wait_done(to);
      got = (rx_q.size() > 0) ? rx_q[0] : 56'h0;
      n_checks++;
      if (to || got !== er) begin n_fail++; $display("FAIL midtx_reg_%0d: got %h expected %h", k, got, er); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) model_regs[i] = 32'h0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    test_write();
    test_readback();
    test_bad_checksum();
    test_line_error();
    test_timeout();
    test_busy_ignore();
    test_random();
    test_reset_mid_tx();
    n_checks++;
    if (n_both != 0) begin n_fail++; $display("FAIL err_and_valid: got %0d overlaps expected 0", n_both); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/onewire_slave.md
# onewire_slave

Responder end of the two-wire one-wire link. It decodes 56-bit command frames arriving on `bus1`, validates them and executes them against a 4 x 32-bit register file. It then drives a 56-bit response frame back on `bus2`. It sits opposite the master in the system and uses the same line coding as the master's transmitter and receiver.

## Interface
- `BIT_PERIOD`, default 64: clk cycles per bit slot. Must be a multiple of 4 and at least 16.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `bus1` inout 1: command line from the master. This block only samples it and never drives it (always `z`).
- `bus2` inout 1: response line, open-drain. Driven `0` or `z`. Pull-up is external.
- `o_command` output 56: last frame that passed validation.
- `o_cmd_valid` output 1: one-cycle pulse when `o_command` updates.
- `o_error` output 1: one-cycle pulse on any line or frame error.
- `o_busy` output 1: high from end of frame reception until the response has been fully sent.

## Operation
- **Line coding** (both buses):
  - Idle is high.
  - A frame starts with a low reset pulse, then 56 bit slots, bit 0 first.
  - Each slot is low then high, totalling `BIT_PERIOD` cycles. Bit `1` is low for `BIT_PERIOD/4`; bit `0` is low for `3*BIT_PERIOD/4`.
- **Frame layout.** Byte i = `frame[8i+7:8i]`.
  - byte0: opcode
  - byte1: address
  - bytes 2..5: data[31:0]
  - byte6: checksum = byte0^byte1^…^byte5
- **RX path.**
  - `bus1` goes through a 2-FF synchroniser. A counter measures each low-pulse length L, and the pulse is classified on its rising edge.
  - L ≥ `4*BIT_PERIOD`: start. Enters RX_BITS with bit index 0, from any RX state.
  - In RX_BITS: L < `BIT_PERIOD/2` → `1`; L < `BIT_PERIOD` → `0`; otherwise → line error.
  - In RX_IDLE: short pulses are ignored.
  - In RX_BITS: high time > `2*BIT_PERIOD` → timeout line error.
  - Line error: pulse `o_error`, return to RX_IDLE, no response sent.
- **EXEC**, entered after bit 55:
  - A frame is valid if its checksum matches, opcode ∈ {0x01, 0x02} and address ≤ 3.
  - Valid 0x01 (write): `reg[addr]` ← data. Response: opcode 0x81, same address, same data.
  - Valid 0x02 (read): response opcode 0x82, same address, data = `reg[addr]`.
  - Valid frame: `o_command` ← frame, pulse `o_cmd_valid`.
  - Invalid frame: pulse `o_error`, registers unchanged. Response: opcode 0xFF, address echoed, data 0.
  - Every response carries a correct checksum.
- **FSM states:** RX_IDLE → RX_BITS → EXEC → TX_WAIT → TX_RST → TX_BITS → RX_IDLE.
- **TX timing:**
  - TX_WAIT lasts `BIT_PERIOD` cycles.
  - TX_RST drives `bus2` low for `8*BIT_PERIOD` cycles, then releases it for `BIT_PERIOD`.
  - TX_BITS sends 56 slots, then returns to RX_IDLE.
- **While busy:** `o_busy`=1 in EXEC/TX_*. Any `bus1` activity during this time is ignored with no error.
- **Reset:**
  - All state → RX_IDLE, `bus2` released, registers = 0.
  - `o_command`=0, `o_cmd_valid`=0, `o_error`=0, `o_busy`=0.
  - Reset mid-TX releases `bus2` asynchronously.

## Timing
- **Decode latency.** A `bus1` rising edge is classified 3 cycles after it occurs (2 sync stages + edge register).
- **EXEC.** Entered on the cycle of the bit-55 classification. EXEC lasts 1 cycle.
- **Execute outputs.** `o_cmd_valid`/`o_error` and the register write happen on the EXEC cycle, with `o_busy` rising in the same cycle.
- **Response start.** The first low cycle of `bus2` comes exactly `BIT_PERIOD`+1 cycles after EXEC.
- **Response length.** Total response duration is `9*BIT_PERIOD` + `56*BIT_PERIOD` cycles.
- **Busy release.** `o_busy` falls on the cycle after the last slot's high phase ends.
- **Pulse-width boundaries.** Classification counts low cycles after synchronisation.
  - L = `BIT_PERIOD/2` exactly → `0`.
  - L = `BIT_PERIOD` exactly → error.
  - L = `4*BIT_PERIOD` exactly → start.
- **Error pulses.** A timeout fires on the cycle the high count reaches `2*BIT_PERIOD`+1. `o_error` and `o_cmd_valid` are never high together.

## Test plan
- **Write.** `BIT_PERIOD`=16. Frame op 0x01, addr 0x02, data 0xDEADBEEF, correct checksum → `o_cmd_valid` pulse, `o_command` = frame. `bus2` response decodes to 0x81/0x02/0xDEADBEEF/checksum.
- **Read-back.** Op 0x02, addr 0x02 → response 0x82/0x02/0xDEADBEEF. A read of addr 0x01 after reset → data 0.
- **Bad checksum.** Checksum byte XOR 0x01 → `o_error` pulse, no `o_cmd_valid`. Response opcode 0xFF with data 0. A follow-up read shows the register unchanged.
- **Line error.** Mid-frame low pulse of `BIT_PERIOD`+2 cycles → `o_error`, `bus2` stays high. The next valid frame is accepted normally.
- **Timeout.** Stop after 20 bits → `o_error` exactly `2*BIT_PERIOD`+1 (+3 sync) cycles after the last rising edge, no response. A frame sent to `bus1` during a response is ignored.
- **Reset mid-response.** Assert `reset` during TX_BITS → `bus2` = `z` immediately, `o_busy`=0, all outputs 0, registers 0.
